// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream boot loader that writes an image into imem and releases the cpu
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds a trailing XOR checksum byte and its check).
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   RX_VALID, RX_DATA     one-cycle byte strobe and received byte
//   LOAD_REQ              leave RUN/ERR and wait for a new image
//   MEM_A, MEM_WE, MEM_WD imem second-port word address, write enable, write data
//   CPU_RESET, CPU_RUN    cpu held in reset except while RUN
//   BUSY, DONE, ERROR     load in progress, image accepted, load failed
module imem_loader #(
  parameter int MAX_WORDS = 1024,
  parameter int TIMEOUT   = 65535
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RX_VALID,
  input  logic [7:0]  RX_DATA,
  input  logic        LOAD_REQ,
  output logic [29:0] MEM_A,
  output logic        MEM_WE,
  output logic [31:0] MEM_WD,
  output logic        CPU_RESET,
  output logic        CPU_RUN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CSUM, RUN, ERR} state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = CSUM;
`else
  localparam state_t POST_DATA = RUN;
`endif

  state_t        state;
  state_t        nxt;
  logic [TW-1:0] timer;
  logic [15:0]   cnt;
  logic [15:0]   widx;
  logic [1:0]    bcnt;
  logic [23:0]   acc;
  logic [15:0]   n_rx;
  logic          tmo;
  logic          in_load;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  // Word count as it will be once the high byte in RX_DATA is captured.
  assign n_rx    = {RX_DATA, cnt[7:0]};
  assign tmo     = (timer == TW'(TIMEOUT - 1));
  assign in_load = (state inside {CNT_LO, CNT_HI, DATA, CSUM});

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (RX_VALID && RX_DATA == 8'hA5) nxt = CNT_LO;
      CNT_LO: begin
        if (RX_VALID) nxt = CNT_HI;
        else if (tmo) nxt = ERR;
      end
      CNT_HI: begin
        if (RX_VALID) begin
          if (n_rx == 16'd0)                        nxt = POST_DATA;
          else if (32'(n_rx) > 32'(MAX_WORDS))      nxt = ERR;
          else                                      nxt = DATA;
        end else if (tmo) begin
          nxt = ERR;
        end
      end
      DATA: begin
        if (RX_VALID) begin
          // Leave on the 4th byte of the last word so the address never wraps.
          if (bcnt == 2'd3 && widx == cnt - 16'd1) nxt = POST_DATA;
        end else if (tmo) begin
          nxt = ERR;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (RX_VALID) nxt = (RX_DATA == csum) ? RUN : ERR;
        else if (tmo) nxt = ERR;
      end
`endif
      RUN, ERR: if (LOAD_REQ) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      timer     <= '0;
      cnt       <= '0;
      widx      <= '0;
      bcnt      <= '0;
      acc       <= '0;
      MEM_A     <= '0;
      MEM_WE    <= 1'b0;
      MEM_WD    <= '0;
      CPU_RESET <= 1'b1;
      CPU_RUN   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERROR     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= nxt;
      MEM_WE    <= 1'b0;
      // Status outputs follow the next state so they change on the entry edge.
      CPU_RESET <= (nxt != RUN);
      CPU_RUN   <= (nxt == RUN);
      DONE      <= (nxt == RUN);
      ERROR     <= (nxt == ERR);
      BUSY      <= (nxt inside {CNT_LO, CNT_HI, DATA, CSUM});

      if (RX_VALID || nxt != state || !in_load) timer <= '0;
      else                                      timer <= timer + TW'(1);

      case (state)
        IDLE: begin
          if (nxt == CNT_LO) begin
            cnt  <= '0;
            widx <= '0;
            bcnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= '0;
`endif
          end
        end
        CNT_LO: if (RX_VALID) cnt[7:0]  <= RX_DATA;
        CNT_HI: if (RX_VALID) cnt[15:8] <= RX_DATA;
        DATA: begin
          if (RX_VALID) begin
            // Bytes shift in from the top so the 4th byte lands as b3.
            acc  <= {RX_DATA, acc[23:8]};
            bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ RX_DATA;
`endif
            if (bcnt == 2'd3) begin
              MEM_WE <= 1'b1;
              MEM_WD <= {RX_DATA, acc};
              MEM_A  <= {14'd0, widx};
              widx   <= widx + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with randomized images
module tb_imem_loader;

  localparam int MAXW = 1024;
  localparam int TMO  = 40;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        RX_VALID = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        LOAD_REQ = 1'b0;
  logic [29:0] MEM_A;
  logic        MEM_WE;
  logic [31:0] MEM_WD;
  logic        CPU_RESET, CPU_RUN, BUSY, DONE, ERROR;

  int total = 0;
  int bad   = 0;

  logic [29:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [7:0]  none[$];

  always #5 CLK = ~CLK;

  imem_loader #(.MAX_WORDS(MAXW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
    .LOAD_REQ(LOAD_REQ), .MEM_A(MEM_A), .MEM_WE(MEM_WE), .MEM_WD(MEM_WD),
    .CPU_RESET(CPU_RESET), .CPU_RUN(CPU_RUN), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Write monitor: every MEM_WE cycle must match the oldest expected write.
  always @(negedge CLK) begin
    if (!RESET && MEM_WE) begin
      if (exp_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual=A%0h/%h expected=no write", MEM_A, MEM_WD);
      end else begin
        chk("write_addr", 32'(MEM_A), 32'(exp_a.pop_front()));
        chk("write_data", MEM_WD, exp_d.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_VALID = 1'b1;
    RX_DATA  = b;
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
    RX_DATA  = 8'($urandom);
  endtask

  task automatic pulse_load(input bit with_sync);
    @(posedge CLK); #1;
    LOAD_REQ = 1'b1;
    if (with_sync) begin
      RX_VALID = 1'b1;
      RX_DATA  = 8'hA5;
    end
    @(posedge CLK); #1;
    LOAD_REQ = 1'b0;
    RX_VALID = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    @(negedge CLK);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_error"}, ERROR, 0);
    chk({tag, "_cpu_reset"}, CPU_RESET, 1);
    chk({tag, "_cpu_run"}, CPU_RUN, 0);
    chk({tag, "_busy"}, BUSY, 0);
  endtask

  // Sends one image, predicts its writes and outcome, then returns to IDLE.
  task automatic run_load(input string tag, input logic [15:0] n, input logic [7:0] data[$],
                          input bit bad_ck, input int maxgap, input bit poke, input bit combo);
    logic [7:0] seq[$];
    logic [7:0] x;
    bit exp_run;
    x = 8'h00;
    seq = {8'hA5, n[7:0], n[15:8]};
    if (int'(n) <= MAXW) begin
      for (int w = 0; w < int'(n); w++) begin
        exp_a.push_back(30'(w));
        exp_d.push_back({data[4*w+3], data[4*w+2], data[4*w+1], data[4*w]});
      end
      foreach (data[i]) begin
        seq.push_back(data[i]);
        x ^= data[i];
      end
      if (CK) seq.push_back(bad_ck ? (x ^ 8'h01) : x);
      exp_run = !(CK && bad_ck);
    end else begin
      exp_run = 1'b0;
    end
    foreach (seq[i]) begin
      send_byte(seq[i]);
      if (maxgap > 0) idle($urandom_range(maxgap, 0));
      if (poke && i < seq.size() - 1 && $urandom_range(3, 0) == 0) pulse_load(1'b0);
    end
    idle(2);
    @(negedge CLK);
    chk({tag, "_done"}, DONE, exp_run);
    chk({tag, "_error"}, ERROR, !exp_run);
    chk({tag, "_cpu_reset"}, CPU_RESET, !exp_run);
    chk({tag, "_cpu_run"}, CPU_RUN, exp_run);
    chk({tag, "_busy"}, BUSY, 0);
    pulse_load(combo);
    chk_idle({tag, "_release"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d[$];
    logic [15:0] n;

    repeat (3) @(negedge CLK);
    chk("rst_mem_a", 32'(MEM_A), 0);
    chk("rst_mem_we", MEM_WE, 0);
    chk("rst_mem_wd", MEM_WD, 0);
    chk("rst_cpu_reset", CPU_RESET, 1);
    chk("rst_cpu_run", CPU_RUN, 0);
    chk("rst_flags", {29'd0, BUSY, DONE, ERROR}, 0);
    RESET = 1'b0;
    idle(2);

    // Reference image, good then bad checksum.
    d = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load("ref_ok", 16'd2, d, 1'b0, 0, 1'b0, 1'b0);
    run_load("ref_badck", 16'd2, d, 1'b1, 0, 1'b0, 1'b0);

    // Oversize count goes straight to ERR with no writes.
    run_load("oversize", 16'd1025, none, 1'b0, 0, 1'b0, 1'b0);
    run_load("max_edge_zero", 16'd0, none, 1'b0, 0, 1'b0, 1'b0);

    // Byte timeout mid-word.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    idle(TMO - 4);
    @(negedge CLK);
    chk("tmo_before_error", ERROR, 0);
    chk("tmo_before_busy", BUSY, 1);
    idle(6);
    @(negedge CLK);
    chk("tmo_error", ERROR, 1);
    chk("tmo_busy", BUSY, 0);
    chk("tmo_cpu_reset", CPU_RESET, 1);
    pulse_load(1'b0);
    chk_idle("tmo_release");

    // Reset between 2nd and 3rd byte of word 1: only word 0 written.
    exp_a.push_back(30'd0);
    exp_d.push_back(32'hDDCCBBAA);
    foreach (d[i]) d[i] = 8'h00;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'hEE); send_byte(8'hFF);
    #2 RESET = 1'b1;
    #1;
    chk("async_rst_we", MEM_WE, 0);
    chk("async_rst_a", 32'(MEM_A), 0);
    chk("async_rst_wd", MEM_WD, 0);
    chk("async_rst_cpu_reset", CPU_RESET, 1);
    chk("async_rst_busy", BUSY, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    run_load("post_reset", 16'd0, none, 1'b0, 0, 1'b0, 1'b0);

    // LOAD_REQ and a sync byte together in RUN: sync byte is dropped.
    run_load("combo", 16'd0, none, 1'b0, 0, 1'b0, 1'b1);

    // Randomized images with noise bytes, gaps and ignored LOAD_REQ pulses.
    for (int it = 0; it < 24; it++) begin
      repeat ($urandom_range(2, 0)) begin
        logic [7:0] nb;
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h5A;
        send_byte(nb);
      end
      chk("noise_ignored", BUSY, 0);
      n = 16'($urandom_range(5, 0));
      d = {};
      for (int k = 0; k < 4 * int'(n); k++) d.push_back(8'($urandom));
      run_load("rand", n, d, ($urandom_range(3, 0) == 0), 5, 1'b1, ($urandom_range(1, 0) == 1));
    end

    idle(3);
    chk("pending_writes", exp_a.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
